// File: rtl/quad_and_pkg.sv
`default_nettype none
// ============================================================================
// Module  : quad_and_pkg
// Purpose : Shared constants for the quad_and lane-wise AND block.
// Contents: QUAD_AND_WIDTH - default lane count used by quad_and.
// Revision: 1.0 - initial release
// ============================================================================
package quad_and_pkg;

    // Default lane count of quad_and.
    localparam int QUAD_AND_WIDTH = 4;

endpackage : quad_and_pkg
`default_nettype wire

// File: rtl/quad_and_and_lane.sv
`default_nettype none
// ============================================================================
// Module  : and_lane
// Purpose : One bit lane of quad_and. Produces the combinational AND of its
//           two operand bits and keeps a registered copy of that result.
// Ports   : clk     - capture clock, rising edge
//           rst_n   - asynchronous active-low reset of the capture flop
//           a_i     - operand A bit
//           b_i     - operand B bit
//           en_i    - capture enable
//           y_o     - a_i & b_i, no clock latency
//           y_q_o   - last captured value of y_o
// Revision: 1.0 - initial release
// ============================================================================
module and_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic a_i,
    input  logic b_i,
    input  logic en_i,
    output logic y_o,
    output logic y_q_o
);

    logic y_d;
    logic y_q;

    // The combinational path never looks at clk, rst_n or en_i.
    assign y_o = a_i & b_i;

    // Hold the stored value unless a capture is requested.
    always_comb begin
        y_d = y_q;
        if (en_i) begin
            y_d = y_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q <= 1'b0;
        end else begin
            y_q <= y_d;
        end
    end

    assign y_q_o = y_q;

endmodule : and_lane
`default_nettype wire

// File: rtl/quad_and.sv
`default_nettype none
// ============================================================================
// Module  : quad_and
// Purpose : WIDTH-lane bitwise AND with a combinational result, a zero flag,
//           and an enable-gated registered copy with a valid flag.
// Ports   : clk       - clock for the registered path, rising edge
//           rst_n     - asynchronous active-low reset of the registered path
//           a, b      - WIDTH-bit operands
//           en        - capture enable for y_q / y_q_valid
//           y         - a & b, combinational
//           y_q       - registered copy of y
//           y_q_valid - set by the first capture after reset
//           y_zero    - high when y is all zeros, combinational
// Revision: 1.0 - initial release
// ============================================================================
module quad_and
    import quad_and_pkg::*;
#(
    parameter int WIDTH = QUAD_AND_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             y_q_valid,
    output logic             y_zero
);

    logic valid_d;
    logic valid_q;

    // Lanes are fully independent: each one sees only its own operand bits.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
            and_lane u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .a_i   (a[gi]),
                .b_i   (b[gi]),
                .en_i  (en),
                .y_o   (y[gi]),
                .y_q_o (y_q[gi])
            );
        end
    endgenerate

    assign y_zero = ~|y;

    // Once set by a capture, valid stays high until the next reset.
    always_comb begin
        valid_d = valid_q;
        if (en) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    assign y_q_valid = valid_q;

endmodule : quad_and
`default_nettype wire

// File: tb/tb_quad_and.sv
`default_nettype none
// ============================================================================
// Module  : tb_quad_and
// Purpose : Self-checking bench for quad_and (WIDTH = 4). Directed vectors
//           plus randomized traffic compared against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_quad_and;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         en;
    logic [W-1:0] y;
    logic [W-1:0] y_q;
    logic         y_q_valid;
    logic         y_zero;

    int total = 0;
    int bad   = 0;
    bit clk_run = 1'b0;

    // Behavioural model of the registered path.
    int mdl_q     = 0;
    int mdl_valid = 0;

    quad_and #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .en        (en),
        .y         (y),
        .y_q       (y_q),
        .y_q_valid (y_q_valid),
        .y_zero    (y_zero)
    );

    // Clock stays idle during the purely combinational phase.
    initial begin
        clk = 1'b0;
        wait (clk_run);
        forever #5 clk = ~clk;
    end

    // Lane-wise AND built from per-bit products.
    function automatic int ref_and(input int av, input int bv);
        int r = 0;
        for (int i = 0; i < W; i++) begin
            r += (((av >> i) & 1) * ((bv >> i) & 1)) << i;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_yq"}, 32'(y_q), 32'(mdl_q));
        chk({tag, "_valid"}, 32'(y_q_valid), 32'(mdl_valid));
    endtask

    // Model a rising edge using the inputs present at that edge.
    task automatic edge_and_check(input string tag);
        int av = int'(a);
        int bv = int'(b);
        bit e  = en;
        @(posedge clk);
        if (rst_n && e) begin
            mdl_q     = ref_and(av, bv);
            mdl_valid = 1;
        end
        #1;
        check_regs(tag);
    endtask

    initial begin
        int av;
        int bv;
        int exp_y;
        int cnt;
        a = '0;
        b = '0;

        // Combinational vectors with clk/rst_n/en left untouched.
        for (int k = 0; k < 4; k++) begin
            a = W'(k >> 1);
            b = W'(k & 1);
            #5;
            chk("comb_vec", 32'(y), 32'(ref_and(k >> 1, k & 1)));
        end

        a = 4'b1111; b = 4'b1010; #5;
        chk("y_1010", 32'(y), 32'(ref_and(15, 10)));
        chk("yzero_0", 32'(y_zero), 32'd0);
        a = 4'b0101; b = 4'b1010; #5;
        chk("y_0000", 32'(y), 32'd0);
        chk("yzero_1", 32'(y_zero), 32'd1);

        // Exhaustive sweep; count disagreements as one comparison.
        cnt = 0;
        for (int p = 0; p < 256; p++) begin
            a = W'(p >> 4);
            b = W'(p & 15);
            #1;
            exp_y = ref_and(p >> 4, p & 15);
            if (int'(y) != exp_y || y_zero != (exp_y == 0)) cnt++;
        end
        chk("sweep_errs", 32'(cnt), 32'd0);

        // Held in reset while clocking with en high.
        rst_n = 1'b0;
        en    = 1'b1;
        a = 4'b1111; b = 4'b1111;
        clk_run = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_y", 32'(y), 32'hF);
        check_regs("rst");

        // First capture after reset release, then a held edge.
        @(negedge clk);
        rst_n = 1'b1;
        a = 4'b1100; b = 4'b0110; en = 1'b1;
        edge_and_check("cap");
        chk("cap_val", 32'(y_q), 32'h4);
        @(negedge clk);
        en = 1'b0; a = 4'b1111; b = 4'b1111;
        edge_and_check("hold");
        chk("hold_val", 32'(y_q), 32'h4);

        // Asynchronous reset between edges.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        mdl_q = 0; mdl_valid = 0;
        #1;
        check_regs("async");
        rst_n = 1'b1;
        @(negedge clk);
        a = 4'b0011; b = 4'b0101; en = 1'b1;
        edge_and_check("post_rst");

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            av = int'($urandom_range(0, 15));
            bv = int'($urandom_range(0, 15));
            a  = W'(av);
            b  = W'(bv);
            en = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_y", 32'(y), 32'(ref_and(av, bv)));
            chk("rnd_zero", 32'(y_zero), 32'(ref_and(av, bv) == 0));
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                mdl_q = 0; mdl_valid = 0;
                #1;
                check_regs("rnd_async");
                chk("rnd_rst_y", 32'(y), 32'(ref_and(av, bv)));
                rst_n = 1'b1;
            end
            edge_and_check("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_quad_and
`default_nettype wire
